// File: rtl/press_arb_pkg.sv
// rtl/press_arb_pkg.sv - shared types, defaults and round-robin search helper
// for the long-press event arbiter.
package press_arb_pkg;

  typedef enum logic [1:0] {
    QS_IDLE = 2'b00,
    QS_HOLD = 2'b01,
    QS_FIRE = 2'b10
  } qs_t;

  localparam int DEFAULT_HOLD_CYC = 1000;

  // First set bit of req found by scanning last+1, last+2, ... modulo n.
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  last,
                                         input int          n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (!found && req[idx[3:0]]) begin
          pick  = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/press_qualifier.sv
// rtl/press_qualifier.sv - per-button long-press qualifier; qual pulses for one
// cycle after a hold of at least HOLD_CYC+1 sampled edges is released.
module press_qualifier
  import press_arb_pkg::*;
#(
  parameter int HOLD_CYC = DEFAULT_HOLD_CYC,
  parameter int CNT_W    = 16
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic btn,
  output logic qual
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC);

  qs_t              q, q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      q   <= QS_IDLE;
      cnt <= '0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    q_nxt   = QS_IDLE;
    cnt_nxt = cnt;
    case (q)
      QS_IDLE: begin
        cnt_nxt = '0;
        if (btn) q_nxt = QS_HOLD;
      end
      QS_HOLD: begin
        if (btn) begin
          q_nxt = QS_HOLD;
          if (cnt < HOLD_MAX) cnt_nxt = cnt + 1'b1;
        end else begin
          q_nxt   = (cnt >= HOLD_MAX) ? QS_FIRE : QS_IDLE;
          cnt_nxt = '0;
        end
      end
      QS_FIRE: begin
        // A button still high here is not merged; it restarts from IDLE.
        q_nxt   = QS_IDLE;
        cnt_nxt = '0;
      end
      default: begin
        q_nxt   = QS_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  assign qual = (q == QS_FIRE);

endmodule

// File: rtl/press_event_arbiter.sv
// rtl/press_event_arbiter.sv - qualifies N_CH buttons as long presses, keeps one
// pending event per channel and round-robins them onto a valid/ready port.
module press_event_arbiter
  import press_arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CH_W     = 2,
  parameter int HOLD_CYC = DEFAULT_HOLD_CYC,
  parameter int CNT_W    = 16
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic            ev_ready,
  output logic            ev_valid,
  output logic [CH_W-1:0] ev_ch,
  output logic [N_CH-1:0] pend,
  output logic [N_CH-1:0] drop
);

  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] rr_last;
  logic [CH_W-1:0] sel;
  logic            load;
  logic            any_pend;

  for (genvar i = 0; i < N_CH; i++) begin : g_qual
    press_qualifier #(
      .HOLD_CYC(HOLD_CYC),
      .CNT_W   (CNT_W)
    ) u_qual (
      .CLOCK_50(CLOCK_50),
      .rst     (rst),
      .btn     (btn[i]),
      .qual    (qual[i])
    );
  end

  assign load     = !ev_valid || ev_ready;
  assign any_pend = |pend;
  assign sel      = CH_W'(rr_pick(16'(pend), 4'(rr_last), N_CH));
  assign gnt      = (load && any_pend) ? (N_CH'(1) << sel) : '0;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pend     <= '0;
      drop     <= '0;
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      rr_last  <= CH_W'(N_CH - 1);
    end else begin
      // A qualify on the very edge its channel is granted is a fresh event.
      pend <= (pend & ~gnt) | qual;
      drop <= qual & pend & ~gnt;
      if (load) begin
        if (any_pend) begin
          ev_valid <= 1'b1;
          ev_ch    <= sel;
          rr_last  <= sel;
        end else begin
          ev_valid <= 1'b0;
        end
      end
    end
  end

endmodule
